// File: rtl/conv_fprop2_mul_pkg.sv
// rtl/conv_fprop2_mul_pkg.sv - shared constants and range helpers for the conv_fprop2 multiplier pipe
package conv_fprop2_mul_pkg;

  // Deepest pipeline the multiplier is meant to be built with
  localparam int MAX_STAGE = 8;

  // Range limits are evaluated in a wide signed domain so no product is narrowed first
  localparam int LIMIT_WIDTH = 64;
  typedef logic signed [LIMIT_WIDTH-1:0] limit_t;

  // Full product width of two operands, each widened by one extension bit
  function automatic int prod_width(input int w0, input int w1);
    return w0 + w1 + 2;
  endfunction

  // Largest value representable in w bits
  function automatic limit_t sat_max(input int w, input logic is_signed);
    limit_t one;
    one = 1;
    return is_signed ? (one <<< (w - 1)) - one : (one <<< w) - one;
  endfunction

  // Smallest value representable in w bits
  function automatic limit_t sat_min(input int w, input logic is_signed);
    limit_t one;
    one = 1;
    return is_signed ? -(one <<< (w - 1)) : '0;
  endfunction

endpackage

// File: rtl/conv_fprop2_mul_pipe_if.sv
// rtl/conv_fprop2_mul_pipe_if.sv - operand/result handshake bundle for the multiplier pipe
interface conv_fprop2_mul_pipe_if #(
  parameter int din0_WIDTH = 11,
  parameter int din1_WIDTH = 6,
  parameter int dout_WIDTH = 16
) ();

  logic                  in_valid;
  logic                  in_ready;
  logic [din0_WIDTH-1:0] din0;
  logic [din1_WIDTH-1:0] din1;
  logic                  sign0;
  logic                  sign1;
  logic                  out_valid;
  logic                  out_ready;
  logic [dout_WIDTH-1:0] dout;
  logic                  out_ovf;

  // Producer of operands and consumer of products
  modport master (
    output in_valid, din0, din1, sign0, sign1, out_ready,
    input  in_ready, out_valid, dout, out_ovf
  );

  // The multiplier pipe itself
  modport slave (
    input  in_valid, din0, din1, sign0, sign1, out_ready,
    output in_ready, out_valid, dout, out_ovf
  );

endinterface

// File: rtl/conv_fprop2_mul_pipe_stage.sv
// rtl/conv_fprop2_mul_pipe_stage.sv - one elastic pipeline slot: valid bit plus payload
module conv_fprop2_mul_pipe_stage #(
  parameter int DATA_WIDTH = 17
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  src_valid,
  input  logic [DATA_WIDTH-1:0] src_data,
  output logic                  src_ready,
  output logic                  dst_valid,
  output logic [DATA_WIDTH-1:0] dst_data,
  input  logic                  dst_ready
);

  logic                  full;
  logic [DATA_WIDTH-1:0] payload;

  // An empty slot always fills; an occupied one only refills as its beat leaves
  assign src_ready = ~full | dst_ready;

  // Slot register; payload is frozen while the occupant is stalled
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      full    <= 1'b0;
      payload <= '0;
    end else if (src_ready) begin
      full <= src_valid;
      if (src_valid) begin
        payload <= src_data;
      end
    end
  end

  assign dst_valid = full;
  assign dst_data  = payload;

endmodule

// File: rtl/conv_fprop2_mul_pipe.sv
// rtl/conv_fprop2_mul_pipe.sv - pipelined signed/unsigned multiplier with truncate or saturate output
module conv_fprop2_mul_pipe
  import conv_fprop2_mul_pkg::*;
#(
  parameter int din0_WIDTH = 11,
  parameter int din1_WIDTH = 6,
  parameter int dout_WIDTH = 16,
  parameter int NUM_STAGE  = 3,
  parameter int SAT        = 0
) (
  input logic                    ap_clk,
  input logic                    ap_rst_n,
  conv_fprop2_mul_pipe_if.slave  bus
);

  localparam int P  = prod_width(din0_WIDTH, din1_WIDTH);
  localparam int PW = dout_WIDTH + 1;
  // A result at least as wide as both operands together can never overflow
  localparam bit NO_OVF = (dout_WIDTH >= din0_WIDTH + din1_WIDTH);

  logic signed [din0_WIDTH:0] a_ext;
  logic signed [din1_WIDTH:0] b_ext;
  logic signed [P-1:0]        a_full;
  logic signed [P-1:0]        b_full;
  logic signed [P-1:0]        prod;
  limit_t                     prod_wide;
  limit_t                     hi;
  limit_t                     lo;
  logic                       res_signed;
  logic                       above;
  logic                       below;
  logic                       ovf;
  logic [dout_WIDTH-1:0]      res;

  // Each operand gains one bit so unsigned and signed inputs share one signed multiplier
  assign a_ext  = {bus.sign0 & bus.din0[din0_WIDTH-1], bus.din0};
  assign b_ext  = {bus.sign1 & bus.din1[din1_WIDTH-1], bus.din1};
  assign a_full = P'(a_ext);
  assign b_full = P'(b_ext);
  assign prod   = a_full * b_full;

  assign prod_wide  = LIMIT_WIDTH'(prod);
  assign res_signed = bus.sign0 | bus.sign1;
  assign hi         = sat_max(dout_WIDTH, res_signed);
  assign lo         = sat_min(dout_WIDTH, res_signed);
  assign above      = prod_wide > hi;
  assign below      = prod_wide < lo;
  assign ovf        = NO_OVF ? 1'b0 : (above | below);

  // Output formatting: wrap to the low bits, or clamp to the nearest limit when saturating
  always_comb begin
    res = dout_WIDTH'(prod_wide);
    if (SAT != 0) begin
      if (above) begin
        res = dout_WIDTH'(hi);
      end else if (below) begin
        res = dout_WIDTH'(lo);
      end
    end
  end

  // Index 0 is the front end; index NUM_STAGE is the output slot
  logic          valid_chain [0:NUM_STAGE];
  logic          ready_chain [0:NUM_STAGE];
  logic [PW-1:0] data_chain  [0:NUM_STAGE];

  assign valid_chain[0]         = bus.in_valid;
  assign data_chain[0]          = {ovf, res};
  assign ready_chain[NUM_STAGE] = bus.out_ready;
  assign bus.in_ready           = ready_chain[0];

  for (genvar i = 1; i <= NUM_STAGE; i++) begin : g_stage
    conv_fprop2_mul_pipe_stage #(
      .DATA_WIDTH (PW)
    ) u_stage (
      .clk       (ap_clk),
      .rst_n     (ap_rst_n),
      .src_valid (valid_chain[i-1]),
      .src_data  (data_chain[i-1]),
      .src_ready (ready_chain[i-1]),
      .dst_valid (valid_chain[i]),
      .dst_data  (data_chain[i]),
      .dst_ready (ready_chain[i])
    );
  end

  assign bus.out_valid            = valid_chain[NUM_STAGE];
  assign {bus.out_ovf, bus.dout}  = data_chain[NUM_STAGE];

endmodule

// File: doc/conv_fprop2_mul_pipe.md
Name: conv_fprop2_mul_pipe

Overview:
- Parametrised, pipelined successor to the fixed-width combinational unsigned multipliers in the conv_fprop2 datapath.
- Supports configurable operand and result widths and NUM_STAGE register stages.
- Signedness is selectable per operand, per transaction.
- Output is either truncated or saturated, with an overflow flag.
- A valid/ready handshake with bubble collapsing lets conv MAC lanes stall without losing products.

Parameters:
- din0_WIDTH, 11, operand A width (bits).
- din1_WIDTH, 6, operand B width (bits).
- dout_WIDTH, 16, result width (bits).
- NUM_STAGE, 3, pipeline register stages; legal range 1..8; latency in cycles.
- SAT, 0, 0 = truncate to low dout_WIDTH bits; 1 = clamp to representable range.

Ports:
- ap_clk  in  1  clock; all state changes on the rising edge.
- ap_rst_n  in  1  reset; synchronous, active-low.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  block can accept a beat this cycle.
- din0  in  din0_WIDTH  operand A.
- din1  in  din1_WIDTH  operand B.
- sign0  in  1  1 = din0 is two's complement; 0 = unsigned.
- sign1  in  1  1 = din1 is two's complement; 0 = unsigned.
- out_valid  out  1  result beat valid.
- out_ready  in  1  downstream accepts the result this cycle.
- dout  out  dout_WIDTH  product.
- out_ovf  out  1  product did not fit in dout_WIDTH; was truncated or clamped.

Behaviour:
- Reset (ap_rst_n=0 at an edge):
  - All stage valid bits clear; out_valid=0, dout=0, out_ovf=0.
  - in_ready may be 1 while reset is held, but no beat is accepted.
  - Reset mid-operation discards every in-flight beat; nothing is emitted afterwards.
- Transfers:
  - Input transfer = in_valid & in_ready.
  - Output transfer = out_valid & out_ready.
  - Inputs are sampled only on an input transfer.
  - dout/out_ovf stay stable while out_valid=1 and out_ready=0.
- Arithmetic:
  - Each operand is extended by one bit: its MSB if its sign flag is 1, else 0.
  - The extended operands are multiplied as signed; full product width is P = din0_WIDTH + din1_WIDTH + 2.
  - The result is signed iff sign0 | sign1.
- Range limits:
  - Signed result: [-2^(dout_WIDTH-1), 2^(dout_WIDTH-1)-1].
  - Unsigned result: [0, 2^dout_WIDTH-1].
  - If dout_WIDTH >= din0_WIDTH + din1_WIDTH + (sign0|sign1 ? 0 : 0) so the full product always fits, out_ovf is constant 0.
- Overflow and output:
  - out_ovf = 1 when the exact product lies outside the limits above.
  - SAT=0: dout = product[dout_WIDTH-1:0].
  - SAT=1: dout = the nearest limit on overflow, else the exact value.
- Pipeline:
  - Product, ovf and result are computed combinationally from the inputs and captured into stage 1.
  - Stages 2..NUM_STAGE are pure delay registers; synthesis may retime the multiplier across them.
  - The last stage drives out_valid, dout and out_ovf.
- Bubble collapsing:
  - Stage k loads when it is empty or stage k+1 (the output for the last stage) is advancing.
  - Define stall_last = out_valid & ~out_ready.
  - in_ready = ~v1 | (stage 1 advances), computed combinationally.
  - Empty stages fill even when the output is stalled, so up to NUM_STAGE beats are buffered under back-pressure.
- Timing and ordering:
  - Latency is exactly NUM_STAGE cycles from input transfer to out_valid with no stall.
  - Throughput is 1 beat/cycle when out_ready is held high.
  - Order is preserved; no beat is dropped or duplicated.
- Simultaneous events:
  - With the pipe full, out_ready=1 and in_valid=1 in the same cycle, both transfers occur.
  - Occupancy is unchanged in that case.
- Boundary operands:
  - The most-negative times most-negative product (e.g. -1024 * -32) must be handled exactly before range checking.
  - No intermediate narrowing is allowed.

Decomposition:
- Package conv_fprop2_mul_pkg holds:
  - MAX_STAGE = 8.
  - Function prod_width(w0, w1) returning w0 + w1 + 2.
  - Functions sat_max(w, signed) and sat_min(w, signed) for the limits.
- One sub-module, conv_fprop2_mul_pipe_stage:
  - Parametrised data width.
  - Holds the valid bit plus payload register.
  - Has load/advance logic and the synchronous active-low clear.
- The top instantiates NUM_STAGE of these in a generate loop, plus the combinational multiply/saturate front end.

Test Plan:
- Reset/latency: defaults, out_ready=1, one beat din0=1000, din1=30, unsigned → out_valid exactly 3 cycles after the transfer. Expected dout=30000, out_ovf=0. Assert ap_rst_n=0 with 2 beats in flight → no output afterwards, out_valid=0.
- Signed modes: din0=11'h7FF (-1), sign0=1; din1=6'd5, sign1=0 → dout=16'hFFFB, ovf=0. Same operands with sign0=0 → dout=10235, ovf=0.
- Overflow, SAT=0 vs SAT=1, dout_WIDTH=8:
  - din0=100, din1=3, unsigned → SAT=0: dout=8'h2C, ovf=1; SAT=1: dout=8'hFF, ovf=1.
  - Signed din0=-64, din1=3 → SAT=1: dout=8'h80 (-128), ovf=1.
- Extreme operands: sign0=sign1=1, din0=-1024, din1=-32 → dout=32768 truncated (16'h8000), ovf=1 with SAT=0; SAT=1 gives 16'h7FFF, ovf=1.
- Back-pressure:
  - Continuous in_valid, out_ready low for 6 cycles → exactly 3 beats absorbed, then in_ready=0.
  - Release → beats emerge in order, 1/cycle, none lost.
  - Random out_ready (50%) over 1000 beats → scoreboard match.
- Bubble fill: out_ready=0 with the pipe holding one beat in the last stage → the next 2 beats are accepted (in_ready=1 twice). Simultaneous accept/emit with a full pipe keeps occupancy constant.
